// File: rtl/seven_seg_mux_n.sv
// seven_seg_mux_n: time-multiplexed N-digit hex seven-segment driver with PWM, blanking and LZ suppression
module seven_seg_mux_n #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_LIMIT    = 5000,
  parameter int PWM_BITS         = 4,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic [4*NUM_DIGITS-1:0] i_Digits,
  input  logic [NUM_DIGITS-1:0]   i_DP,
  input  logic [NUM_DIGITS-1:0]   i_Blank,
  input  logic                    i_LZ_Suppress,
  input  logic [PWM_BITS-1:0]     i_Brightness,
  input  logic                    i_Load,
  output logic [NUM_DIGITS-1:0]   o_Anode,
  output logic [7:0]              o_Segment,
  output logic                    o_Frame_Done
);
  localparam int RW = $clog2(REFRESH_LIMIT);
  localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [RW-1:0]           ref_cnt;
  logic [SW-1:0]           scan;
  logic [PWM_BITS-1:0]     pwm_cnt;
  logic [4*NUM_DIGITS-1:0] sh_digits, ds_digits;
  logic [NUM_DIGITS-1:0]   sh_dp, ds_dp, sh_blank, ds_blank;
  logic                    sh_lz, ds_lz;
  logic [PWM_BITS-1:0]     sh_bri, ds_bri;
  logic                    ref_last, frame_end, dp_bit, blank_bit, suppress, lit;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [7:0]              seg_next;
  assign ref_last  = ref_cnt == RW'(REFRESH_LIMIT - 1);
  assign frame_end = ref_last && scan == SW'(NUM_DIGITS - 1);
  // A digit is blanked by LZ only if it and every more-significant nibble are zero
  always_comb begin
    nib       = 4'h0;
    dp_bit    = 1'b0;
    blank_bit = 1'b0;
    suppress  = ds_lz && scan != '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (SW'(k) == scan) begin
        nib       = ds_digits[4*k +: 4];
        dp_bit    = ds_dp[k];
        blank_bit = ds_blank[k];
      end
      if (SW'(k) >= scan && ds_digits[4*k +: 4] != 4'h0) suppress = 1'b0;
    end
    lit      = ref_cnt != '0 && !blank_bit && pwm_cnt <= ds_bri;
    an_next  = lit ? NUM_DIGITS'(1) << scan : '0;
    seg_next = {dp_bit, suppress ? 7'h00 : GLYPH[nib]};
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      ref_cnt      <= '0;
      scan         <= '0;
      pwm_cnt      <= '0;
      sh_digits    <= '0;
      ds_digits    <= '0;
      sh_dp        <= '0;
      ds_dp        <= '0;
      sh_blank     <= '0;
      ds_blank     <= '0;
      sh_lz        <= 1'b0;
      ds_lz        <= 1'b0;
      sh_bri       <= '1;
      ds_bri       <= '1;
      o_Anode      <= AN_OFF;
      o_Segment    <= SEG_OFF;
      o_Frame_Done <= 1'b0;
    end else begin
      ref_cnt <= ref_last ? '0 : ref_cnt + 1'b1;
      if (ref_last) scan <= scan == SW'(NUM_DIGITS - 1) ? '0 : scan + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (i_Load) begin
        sh_digits <= i_Digits;
        sh_dp     <= i_DP;
        sh_blank  <= i_Blank;
        sh_lz     <= i_LZ_Suppress;
        sh_bri    <= i_Brightness;
      end
      // Display takes the pre-edge shadow, so a coincident load shows next frame
      if (frame_end) begin
        ds_digits <= sh_digits;
        ds_dp     <= sh_dp;
        ds_blank  <= sh_blank;
        ds_lz     <= sh_lz;
        ds_bri    <= sh_bri;
      end
      o_Anode      <= an_next ^ AN_OFF;
      o_Segment    <= seg_next ^ SEG_OFF;
      o_Frame_Done <= frame_end;
    end
  end
endmodule
